screen_text_ctrl: RTL and testbench
===================================

# screen_text_ctrl

Sequencing controller for the text-mode `screen_ram` (80×30 cells of 8×16 pixels, addressed as `{row[4:0], col[6:0]}`). It accepts character, newline and clear commands over a valid/ready handshake, keeps a text cursor, and converts hex digits to ASCII. It issues at most one registered write per cycle to the RAM write port, replacing the free-running write-at-scan-position path. The pixel/scan read side of `screen_ram` is untouched.

## Interface
Parameters:
- `COLS`, 80, visible text columns (1..128).
- `ROWS`, 30, visible text rows (1..32).
- `CLEAR_CHAR`, 8'h20, byte written to every cell on clear.

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  controller accepts a command this cycle.
- `cmd_op`  in  2  00 = hex digit, 01 = raw ASCII, 10 = newline, 11 = clear screen.
- `cmd_data`  in  8  hex digit in [3:0] for op 00 ([7:4] ignored); byte for op 01; ignored otherwise.
- `ram_we`  out  1  write strobe to `screen_ram`.
- `ram_addr`  out  12  `{row[4:0], col[6:0]}`.
- `ram_data`  out  8  byte to write.
- `cursor_col`  out  7  current cursor column.
- `cursor_row`  out  5  current cursor row.
- `busy`  out  1  high while a clear is in progress.

## Operation
- States: CLEAR, IDLE, WRITE.
- Reset state is CLEAR with clear counter {row 0, col 0}.
- CLEAR:
  - Write `CLEAR_CHAR` to one cell per cycle, row-major, col 0..COLS-1 within row 0..ROWS-1. Total COLS×ROWS writes; 2400 with defaults.
  - Columns ≥ COLS are never written.
  - After the write to cell (ROWS-1, COLS-1): go to IDLE with cursor = (0,0).
- IDLE:
  - `cmd_ready` = 1. A command is accepted when `cmd_valid && cmd_ready`.
  - op 00: go to WRITE with data = ASCII of the digit. 0–9 map to 8'h30–8'h39; A–F map to 8'h41–8'h46 (uppercase).
  - op 01: go to WRITE with data = `cmd_data`.
  - op 10 (newline): no RAM write. Set col = 0 and row = row+1, wrapping ROWS-1 → 0. Stay in IDLE.
  - op 11: go to CLEAR with the counter reset to (0,0).
- WRITE:
  - One cycle. `ram_we` = 1, `ram_addr` = cursor, `ram_data` = latched byte.
  - Then advance the cursor: col+1; at COLS-1, col = 0 and row+1. Row wraps ROWS-1 → 0.
  - No scrolling. Return to IDLE.
- `cmd_ready` = 0 in CLEAR and WRITE. `cmd_valid` in those states is ignored, and the command must be held by the requester.
- `busy` = 1 exactly when the state is CLEAR.
- The cursor is never outside [0,COLS-1] × [0,ROWS-1].

## Timing
- All outputs are registered; there is no combinational path from `cmd_*` to `ram_*`.
- Reset values: `ram_we` = 0, `ram_addr` = 0, `ram_data` = `CLEAR_CHAR`, `cmd_ready` = 0, `busy` = 1, `cursor_col` = 0, `cursor_row` = 0.
- First clear write (`ram_we` = 1, addr 0) appears in the first cycle after `reset` deasserts. `ram_we` then stays high for COLS×ROWS consecutive cycles.
- `cmd_ready` rises in the cycle after the last clear write.
- Character command accepted at edge N:
  - `ram_we` is high during cycle N+1 with the pre-advance cursor address.
  - The cursor outputs update at edge N+2.
  - `cmd_ready` returns at N+2.
  - Maximum throughput is one character per 2 cycles.
- Newline accepted at edge N: cursor updates at N+1, `cmd_ready` stays high, throughput is 1 per cycle.
- Clear accepted at edge N: `busy` = 1 and the first clear write both occur in cycle N+1.
- `reset` asserted in any state, including mid-CLEAR or WRITE, wins at the next edge. Any pending write is dropped and the full clear sequence restarts.

## Test plan
- Reset 3 cycles, then release. Require:
  - exactly 2400 writes of 8'h20, row-major, addresses from 12'h000 through {5'd29, 7'd79};
  - no address with col ≥ 80 is written;
  - `cmd_ready` rises on cycle 2401;
  - cursor = (0,0).
- After the clear, send op 00 with digits 4'h9 then 4'hA. Require writes 8'h39 @ {0,0} and 8'h41 @ {0,1}, cursor = (0,2), and `cmd_ready` low one cycle after each accept.
- Place the cursor at (0,79) and write op 01 with 8'h58. Require a write @ {0,79} and cursor = (1,0). Then from cursor (29,79), one write gives cursor = (0,0).
- Hold `cmd_valid` continuously with a newline at cursor (29,5). Require no `ram_we`, cursor = (0,0) next cycle, and a second newline accepted on the immediately following edge, giving cursor = (1,0).
- Issue op 11 at cursor (7,12), and hold `cmd_valid` with an op 00 during the clear. Require `busy` high for 2400 cycles, the held command not accepted until IDLE, then written at {0,0}.
- Assert `reset` midway through a clear (after 1000 writes) and again during a WRITE cycle. Require outputs at reset values on the next edge and the clear restarting at address 0 after release.

Source files
------------

// File: rtl/screen_text_ctrl.sv
// Text-mode write sequencer for screen_ram: clears the screen, then turns
// hex/ASCII/newline/clear commands into single registered cell writes at a cursor.
module screen_text_ctrl #(
    parameter int          COLS       = 80,
    parameter int          ROWS       = 30,
    parameter logic [7:0]  CLEAR_CHAR = 8'h20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [7:0]  cmd_data,
    output logic        ram_we,
    output logic [11:0] ram_addr,
    output logic [7:0]  ram_data,
    output logic [6:0]  cursor_col,
    output logic [4:0]  cursor_row,
    output logic        busy
);

    // state    | meaning
    // ST_CLEAR | one CLEAR_CHAR write per cycle, row-major over the visible area
    // ST_IDLE  | cmd_ready high, accepting commands
    // ST_WRITE | one-cycle write of the latched byte at the cursor, then advance
    typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_WRITE} state_t;

    localparam logic [6:0] LAST_COL = 7'(COLS - 1);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

    state_t      state, state_n;
    logic [6:0]  clr_col, clr_col_n, cur_col, cur_col_n;
    logic [4:0]  clr_row, clr_row_n, cur_row, cur_row_n;
    logic [7:0]  wr_byte, wr_byte_n;
    logic        ram_we_n, cmd_ready_n, busy_n;
    logic [11:0] ram_addr_n;
    logic [7:0]  ram_data_n, hex_ascii;
    logic [4:0]  cur_row_inc;

    assign hex_ascii   = (cmd_data[3:0] < 4'd10) ? 8'h30 + {4'h0, cmd_data[3:0]}
                                                 : 8'h37 + {4'h0, cmd_data[3:0]};
    assign cur_row_inc = (cur_row == LAST_ROW) ? 5'd0 : cur_row + 5'd1;

    always_comb begin
        state_n     = state;
        clr_col_n   = clr_col;
        clr_row_n   = clr_row;
        cur_col_n   = cur_col;
        cur_row_n   = cur_row;
        wr_byte_n   = wr_byte;
        ram_we_n    = 1'b0;
        ram_addr_n  = ram_addr;
        ram_data_n  = ram_data;
        cmd_ready_n = 1'b0;
        busy_n      = 1'b0;
        case (state)
            ST_CLEAR: begin
                ram_we_n   = 1'b1;
                ram_addr_n = {clr_row, clr_col};
                ram_data_n = CLEAR_CHAR;
                busy_n     = 1'b1;
                if (clr_col == LAST_COL) begin
                    clr_col_n = 7'd0;
                    if (clr_row == LAST_ROW) begin
                        clr_row_n = 5'd0;
                        cur_col_n = 7'd0;
                        cur_row_n = 5'd0;
                        state_n   = ST_IDLE;
                    end else begin
                        clr_row_n = clr_row + 5'd1;
                    end
                end else begin
                    clr_col_n = clr_col + 7'd1;
                end
            end
            ST_IDLE: begin
                cmd_ready_n = 1'b1;
                if (cmd_valid && cmd_ready) begin
                    case (cmd_op)
                        2'b00: begin
                            wr_byte_n   = hex_ascii;
                            state_n     = ST_WRITE;
                            cmd_ready_n = 1'b0;
                        end
                        2'b01: begin
                            wr_byte_n   = cmd_data;
                            state_n     = ST_WRITE;
                            cmd_ready_n = 1'b0;
                        end
                        2'b10: begin
                            cur_col_n = 7'd0;
                            cur_row_n = cur_row_inc;
                        end
                        default: begin
                            clr_col_n   = 7'd0;
                            clr_row_n   = 5'd0;
                            state_n     = ST_CLEAR;
                            cmd_ready_n = 1'b0;
                        end
                    endcase
                end
            end
            ST_WRITE: begin
                ram_we_n   = 1'b1;
                ram_addr_n = {cur_row, cur_col};
                ram_data_n = wr_byte;
                if (cur_col == LAST_COL) begin
                    cur_col_n = 7'd0;
                    cur_row_n = cur_row_inc;
                end else begin
                    cur_col_n = cur_col + 7'd1;
                end
                state_n = ST_IDLE;
            end
            default: state_n = ST_CLEAR;
        endcase
    end

    // Cursor outputs trail the internal cursor by one edge so a character
    // shows its new cursor together with cmd_ready returning.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_CLEAR;
            clr_col    <= 7'd0;
            clr_row    <= 5'd0;
            cur_col    <= 7'd0;
            cur_row    <= 5'd0;
            wr_byte    <= CLEAR_CHAR;
            ram_we     <= 1'b0;
            ram_addr   <= 12'd0;
            ram_data   <= CLEAR_CHAR;
            cmd_ready  <= 1'b0;
            busy       <= 1'b1;
            cursor_col <= 7'd0;
            cursor_row <= 5'd0;
        end else begin
            state      <= state_n;
            clr_col    <= clr_col_n;
            clr_row    <= clr_row_n;
            cur_col    <= cur_col_n;
            cur_row    <= cur_row_n;
            wr_byte    <= wr_byte_n;
            ram_we     <= ram_we_n;
            ram_addr   <= ram_addr_n;
            ram_data   <= ram_data_n;
            cmd_ready  <= cmd_ready_n;
            busy       <= busy_n;
            cursor_col <= cur_col;
            cursor_row <= cur_row;
        end
    end

endmodule

// File: tb/tb_screen_text_ctrl.sv
// Directed + randomized bench for screen_text_ctrl against a cursor/screen model.
module tb_screen_text_ctrl;
    localparam int COLS = 80;
    localparam int ROWS = 30;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [7:0]  cmd_data = 8'h00;
    logic        ram_we;
    logic [11:0] ram_addr;
    logic [7:0]  ram_data;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int exp_row = 0;
    int exp_col = 0;
    int wide_writes = 0;
    logic [7:0] model_mem [4096];
    logic [7:0] scr [4096];

    screen_text_ctrl dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_data(ram_data), .cursor_col(cursor_col), .cursor_row(cursor_row),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (ram_we === 1'b1) begin
            scr[ram_addr] = ram_data;
            if (int'(ram_addr[6:0]) >= COLS) wide_writes++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ascii_of(input logic [3:0] d);
        int v;
        v = int'(d);
        return (v < 10) ? 8'(48 + v) : 8'(65 + v - 10);
    endfunction

    task automatic check_reset_vals(input string tag);
        chk({tag, ".we"}, ram_we, 0);
        chk({tag, ".addr"}, ram_addr, 0);
        chk({tag, ".data"}, ram_data, 8'h20);
        chk({tag, ".ready"}, cmd_ready, 0);
        chk({tag, ".busy"}, busy, 1);
        chk({tag, ".col"}, cursor_col, 0);
        chk({tag, ".row"}, cursor_row, 0);
    endtask

    // Expects the clear to emit its k-th write in the k-th sampled cycle.
    task automatic run_clear(input string tag, input int limit);
        int bad;
        logic [11:0] a;
        bad = 0;
        for (int k = 0; k < limit; k++) begin
            tick();
            a = {5'(k / COLS), 7'(k % COLS)};
            if (ram_we !== 1'b1 || ram_addr !== a || ram_data !== 8'h20 ||
                busy !== 1'b1 || cmd_ready !== 1'b0) bad++;
        end
        chk({tag, ".writes"}, bad, 0);
        if (limit == COLS * ROWS) begin
            tick();
            chk({tag, ".ready_after"}, cmd_ready, 1);
            chk({tag, ".busy_after"}, busy, 0);
            chk({tag, ".we_after"}, ram_we, 0);
            chk({tag, ".cursor"}, {cursor_row, cursor_col}, 0);
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) model_mem[r * 128 + c] = 8'h20;
            exp_row = 0;
            exp_col = 0;
        end
    endtask

    task automatic wait_ready(input string tag);
        int t;
        t = 0;
        while (cmd_ready !== 1'b1 && t < 3000) begin
            tick();
            t++;
        end
        chk({tag, ".ready_wait"}, cmd_ready, 1);
    endtask

    // Called right after the sample following the accepting edge.
    task automatic char_after_accept(input logic [7:0] b, input string tag);
        chk({tag, ".ready_low"}, cmd_ready, 0);
        chk({tag, ".we_early"}, ram_we, 0);
        tick();
        chk({tag, ".we"}, ram_we, 1);
        chk({tag, ".addr"}, ram_addr, {exp_row[4:0], exp_col[6:0]});
        chk({tag, ".data"}, ram_data, b);
        model_mem[exp_row * 128 + exp_col] = b;
        exp_col++;
        if (exp_col == COLS) begin
            exp_col = 0;
            exp_row = (exp_row + 1) % ROWS;
        end
        tick();
        chk({tag, ".cursor"}, {cursor_row, cursor_col}, {exp_row[4:0], exp_col[6:0]});
        chk({tag, ".ready_back"}, cmd_ready, 1);
        chk({tag, ".we_off"}, ram_we, 0);
    endtask

    task automatic send_char(input logic [1:0] op, input logic [7:0] d, input string tag);
        wait_ready(tag);
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_data = d;
        tick();
        cmd_valid = 1'b0;
        char_after_accept((op == 2'b00) ? ascii_of(d[3:0]) : d, tag);
    endtask

    task automatic send_nl(input string tag);
        wait_ready(tag);
        cmd_valid = 1'b1;
        cmd_op = 2'b10;
        tick();
        cmd_valid = 1'b0;
        chk({tag, ".we"}, ram_we, 0);
        chk({tag, ".ready"}, cmd_ready, 1);
        exp_col = 0;
        exp_row = (exp_row + 1) % ROWS;
        tick();
        chk({tag, ".cursor"}, {cursor_row, cursor_col}, {exp_row[4:0], exp_col[6:0]});
    endtask

    task automatic goto(input int row, input int col);
        send_nl("goto_nl");
        while (exp_row != row) send_nl("goto_nl");
        while (exp_col != col) send_char(2'b01, 8'($urandom_range(32, 126)), "goto_chr");
    endtask

    initial begin
        logic [7:0] d;
        int bad;

        repeat (3) tick();
        check_reset_vals("reset");
        reset = 1'b0;
        run_clear("init_clear", COLS * ROWS);

        send_char(2'b00, 8'h09, "hex9");
        send_char(2'b00, 8'hFA, "hexA");
        chk("cursor_0_2", {cursor_row, cursor_col}, {5'd0, 7'd2});

        goto(0, 79);
        send_char(2'b01, 8'h58, "col_wrap");
        chk("col_wrap.row1", {cursor_row, cursor_col}, {5'd1, 7'd0});
        goto(29, 79);
        send_char(2'b01, 8'($urandom), "screen_wrap");
        chk("screen_wrap.origin", {cursor_row, cursor_col}, 0);

        for (int i = 0; i < 40; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 2) send_nl("rand_nl");
            else if (r < 6) send_char(2'b00, 8'($urandom), "rand_hex");
            else send_char(2'b01, 8'($urandom), "rand_raw");
            repeat ($urandom_range(0, 2)) tick();
        end

        goto(29, 5);
        wait_ready("held_nl");
        cmd_valid = 1'b1;
        cmd_op = 2'b10;
        tick();
        chk("held_nl.we1", ram_we, 0);
        chk("held_nl.ready1", cmd_ready, 1);
        tick();
        chk("held_nl.cursor1", {cursor_row, cursor_col}, 0);
        chk("held_nl.we2", ram_we, 0);
        cmd_valid = 1'b0;
        tick();
        chk("held_nl.cursor2", {cursor_row, cursor_col}, {5'd1, 7'd0});
        exp_row = 1;
        exp_col = 0;

        goto(7, 12);
        wait_ready("op11");
        cmd_valid = 1'b1;
        cmd_op = 2'b11;
        tick();
        d = 8'($urandom);
        cmd_op = 2'b00;
        cmd_data = d;
        chk("op11.ready_low", cmd_ready, 0);
        run_clear("op11_clear", COLS * ROWS);
        tick();
        cmd_valid = 1'b0;
        char_after_accept(ascii_of(d[3:0]), "held_cmd");

        reset = 1'b1;
        tick();
        check_reset_vals("reset_idle");
        reset = 1'b0;
        run_clear("part_clear", 1000);
        reset = 1'b1;
        tick();
        check_reset_vals("reset_mid_clear");
        reset = 1'b0;
        run_clear("restart_clear", COLS * ROWS);

        send_char(2'b01, 8'h41, "pre_write");
        wait_ready("drop_write");
        cmd_valid = 1'b1;
        cmd_op = 2'b01;
        cmd_data = 8'h7E;
        tick();
        cmd_valid = 1'b0;
        reset = 1'b1;
        tick();
        check_reset_vals("reset_in_write");
        reset = 1'b0;
        run_clear("restart_clear2", COLS * ROWS);
        send_char(2'b00, 8'h0C, "final_hex");

        tick();
        tick();
        bad = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (scr[r * 128 + c] !== model_mem[r * 128 + c]) bad++;
        chk("screen_contents", bad, 0);
        chk("no_wide_writes", wide_writes, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
